// File: rtl/dmem_pkg.sv
// Shared types and constants for the
// memory-stage data-memory access unit.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic       SIZE_WORD = 1'b0;
  localparam logic       SIZE_BYTE = 1'b1;
  localparam logic [3:0] BE_WORD   = 4'b1111;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatting: byte enables, store
// replication and zero-extended load lanes.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic        size_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  // Word access passes through; byte access selects one lane.
  always_comb begin
    be_o    = BE_WORD;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    if (size_i == SIZE_BYTE) begin
      wdata_o = {4{wdata_i[7:0]}};
      unique case (off_i)
        2'd0: begin
          be_o    = 4'b0001;
          rdata_o = {24'h0, rdata_i[7:0]};
        end
        2'd1: begin
          be_o    = 4'b0010;
          rdata_o = {24'h0, rdata_i[15:8]};
        end
        2'd2: begin
          be_o    = 4'b0100;
          rdata_o = {24'h0, rdata_i[23:16]};
        end
        default: begin
          be_o    = 4'b1000;
          rdata_o = {24'h0, rdata_i[31:24]};
        end
      endcase
    end
  end

endmodule

// File: rtl/dmem_access_unit.sv
// M-stage data-memory interface: req/ready bus
// transaction with stall, timeout and lane formatting.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemReadM,
  input  logic          MemWriteM,
  input  logic          ByteM,
  input  logic [AW-1:0] ALUOutM,
  input  logic [31:0]   WriteDataM,
  output logic [31:0]   ReadDataM,
  output logic          MemStallM,
  output logic          MisalignM,
  output logic          BusErrM,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-3:0] bus_addr,
  output logic [3:0]    bus_be,
  output logic [31:0]   bus_wdata,
  input  logic          bus_ready,
  input  logic [31:0]   bus_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          req_q;
  logic          we_q;
  logic [AW-3:0] addr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [1:0]    off_q;
  logic          size_q;

  logic          mem_op;
  logic          aligned;
  logic          access;
  logic          misal;
  logic          tmo_hit;
  logic [1:0]    fmt_off;
  logic          fmt_size;
  logic [3:0]    fmt_be;
  logic [31:0]   fmt_wdata;
  logic [31:0]   fmt_rdata;

  assign mem_op  = MemReadM | MemWriteM;
  assign aligned = (ALUOutM[1:0] == 2'b00);
  assign access  = mem_op & (aligned | ByteM);
  assign misal   = mem_op & ~ByteM & ~aligned;
  assign tmo_hit = (cnt_q == CW'(TIMEOUT - 1));

  // Live inputs drive the formatter while idle, the latched
  // offset/size while the transaction is in flight.
  assign fmt_off  = (state_q == IDLE) ? ALUOutM[1:0] : off_q;
  assign fmt_size = (state_q == IDLE) ? ByteM : size_q;

  dmem_lane_fmt u_fmt (
    .off_i   (fmt_off),
    .size_i  (fmt_size),
    .wdata_i (WriteDataM),
    .rdata_i (bus_rdata),
    .be_o    (fmt_be),
    .wdata_o (fmt_wdata),
    .rdata_o (fmt_rdata)
  );

  // Stall is combinational so the pipeline freezes in the
  // same cycle an access first appears.
  assign MemStallM = reset & (((state_q == IDLE) & access)
                            | (state_q == BUSY));
  assign MisalignM = reset & (state_q == IDLE) & misal;

  assign ReadDataM = rdata_q;
  assign BusErrM   = err_q;
  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;

  // Transaction FSM with registered bus and result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'b0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      off_q   <= 2'b0;
      size_q  <= SIZE_WORD;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (access) begin
            state_q <= BUSY;
            req_q   <= 1'b1;
            we_q    <= MemWriteM;
            addr_q  <= ALUOutM[AW-1:2];
            be_q    <= fmt_be;
            wdata_q <= fmt_wdata;
            off_q   <= ALUOutM[1:0];
            size_q  <= ByteM;
            cnt_q   <= '0;
            rdata_q <= 32'h0;
          end
        end
        BUSY: begin
          if (bus_ready) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            if (!we_q) rdata_q <= fmt_rdata;
          end else if (tmo_hit) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b1;
            rdata_q <= 32'h0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          rdata_q <= 32'h0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit with a
// programmable-latency bus slave.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemReadM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic        ByteM = 1'b0;
  logic [31:0] ALUOutM = 32'h0;
  logic [31:0] WriteDataM = 32'h0;
  logic [31:0] ReadDataM;
  logic        MemStallM;
  logic        MisalignM;
  logic        BusErrM;
  logic        bus_req;
  logic        bus_we;
  logic [29:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  always #5 clk = ~clk;

  dmem_access_unit #(.TIMEOUT(16), .AW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .ByteM      (ByteM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .MemStallM  (MemStallM),
    .MisalignM  (MisalignM),
    .BusErrM    (BusErrM),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ready  (bus_ready),
    .bus_rdata  (bus_rdata)
  );

  // kind: 0 normal, 1 misaligned, 2 aborted by reset
  typedef struct {
    int          kind;
    logic [29:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          stall;
    int          busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, req);
    end
  endtask

  function automatic exp_t mk(
    input int k, input logic [29:0] a,
    input logic w, input logic [3:0] b,
    input logic [31:0] wd, input logic [31:0] rd,
    input logic e, input int s, input int bz);
    exp_t x;
    x.kind  = k;
    x.addr  = a;
    x.we    = w;
    x.be    = b;
    x.wdata = wd;
    x.rdata = rd;
    x.err   = e;
    x.stall = s;
    x.busy  = bz;
    return x;
  endfunction

  // Slave: ready after slv_wait BUSY cycles
  int          slv_wait = 0;
  logic        slv_never = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  int          slv_cnt = 0;

  always @(negedge clk) begin
    if (!reset || !bus_req) begin
      bus_ready = 1'b0;
      bus_rdata = 32'h0;
      slv_cnt   = 0;
    end else begin
      if (!slv_never && slv_cnt == slv_wait) begin
        bus_ready = 1'b1;
        bus_rdata = slv_rdata;
      end else begin
        bus_ready = 1'b0;
      end
      slv_cnt++;
    end
  end

  // Monitor: checks bus phase, completion, misalign
  int          stall_cnt = 0;
  int          busy_cnt = 0;
  logic        prev_req = 1'b0;
  logic [66:0] snap = '0;

  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) begin
      if (busy_cnt > 0) begin
        if (exp_q.size() == 0)
          chk("abort_head", 32'd0, 32'd1);
        else begin
          e = exp_q.pop_front();
          chk("abort_kind", e.kind, 32'd2);
        end
      end
      stall_cnt = 0;
      busy_cnt  = 0;
      prev_req  = 1'b0;
    end else begin
      if (MemStallM) stall_cnt++;
      if (bus_req) begin
        busy_cnt++;
        if (busy_cnt == 1) begin
          if (exp_q.size() == 0)
            chk("spurious_req", 32'd1, 32'd0);
          else begin
            e = exp_q[0];
            chk("bus_addr", {2'b0, bus_addr},
                {2'b0, e.addr});
            chk("bus_we", {31'b0, bus_we},
                {31'b0, e.we});
            chk("bus_be", {28'b0, bus_be},
                {28'b0, e.be});
            chk("bus_wdata", bus_wdata, e.wdata);
          end
          snap = {bus_addr, bus_we, bus_be, bus_wdata};
        end else begin
          chk("bus_stable",
              {31'b0, snap == {bus_addr, bus_we,
                               bus_be, bus_wdata}},
              32'd1);
        end
      end else if (prev_req) begin
        if (exp_q.size() == 0)
          chk("done_head", 32'd0, 32'd1);
        else begin
          e = exp_q.pop_front();
          chk("done_kind", e.kind, 32'd0);
          chk("ReadDataM", ReadDataM, e.rdata);
          chk("BusErrM", {31'b0, BusErrM},
              {31'b0, e.err});
          chk("done_stall", {31'b0, MemStallM}, 32'd0);
          chk("stall_cycles", stall_cnt, e.stall);
          chk("busy_cycles", busy_cnt, e.busy);
        end
        stall_cnt = 0;
        busy_cnt  = 0;
      end
      if (MisalignM) begin
        if (exp_q.size() == 0)
          chk("misal_head", 32'd0, 32'd1);
        else begin
          e = exp_q.pop_front();
          chk("misal_kind", e.kind, 32'd1);
          chk("misal_stall", {31'b0, MemStallM}, 32'd0);
          chk("misal_rdata", ReadDataM, 32'd0);
          chk("misal_req", {31'b0, bus_req}, 32'd0);
        end
        stall_cnt = 0;
      end
      prev_req = bus_req;
    end
  end

  task automatic access(
    input logic rd, input logic wr, input logic bt,
    input logic [31:0] a, input logic [31:0] wd,
    input int wt, input logic nev,
    input logic [31:0] rdv, input exp_t e);
    int n;
    bit done;
    slv_wait   = wt;
    slv_never  = nev;
    slv_rdata  = rdv;
    exp_q.push_back(e);
    MemReadM   = rd;
    MemWriteM  = wr;
    ByteM      = bt;
    ALUOutM    = a;
    WriteDataM = wd;
    if (e.kind == 1) begin
      @(posedge clk); #1;
    end else begin
      n = 0;
      done = 1'b0;
      @(posedge clk); #1;
      while (!done && n < 64) begin
        @(posedge clk); #1;
        n++;
        if (!MemStallM) done = 1'b1;
      end
      if (!done) chk("done_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
    end
    MemReadM   = 1'b0;
    MemWriteM  = 1'b0;
    ByteM      = 1'b0;
    ALUOutM    = 32'h0;
    WriteDataM = 32'h0;
  endtask

  task automatic chk_rst_outs(input string pfx);
    chk({pfx, "_req"}, {31'b0, bus_req}, 32'd0);
    chk({pfx, "_we"}, {31'b0, bus_we}, 32'd0);
    chk({pfx, "_addr"}, {2'b0, bus_addr}, 32'd0);
    chk({pfx, "_be"}, {28'b0, bus_be}, 32'd0);
    chk({pfx, "_wdata"}, bus_wdata, 32'd0);
    chk({pfx, "_rdata"}, ReadDataM, 32'd0);
    chk({pfx, "_stall"}, {31'b0, MemStallM}, 32'd0);
    chk({pfx, "_misal"}, {31'b0, MisalignM}, 32'd0);
    chk({pfx, "_berr"}, {31'b0, BusErrM}, 32'd0);
  endtask

  initial begin
    #2;
    chk_rst_outs("rst");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    access(1, 0, 0, 32'h10, 32'h0, 0, 0,
           32'hDEADBEEF,
           mk(0, 30'h4, 0, 4'hF, 32'h0,
              32'hDEADBEEF, 0, 2, 1));
    access(0, 1, 1, 32'h3, 32'h123456A5, 3, 0,
           32'h0,
           mk(0, 30'h0, 1, 4'h8, 32'hA5A5A5A5,
              32'h0, 0, 5, 4));
    access(1, 0, 1, 32'h102, 32'h0, 0, 0,
           32'h11223344,
           mk(0, 30'h40, 0, 4'h4, 32'h0,
              32'h22, 0, 2, 1));
    access(1, 0, 0, 32'h6, 32'h0, 0, 0, 32'h0,
           mk(1, 30'h0, 0, 4'h0, 32'h0,
              32'h0, 0, 0, 0));
    access(1, 0, 0, 32'h20, 32'h0, 0, 1,
           32'hFFFFFFFF,
           mk(0, 30'h8, 0, 4'hF, 32'h0,
              32'h0, 1, 17, 16));
    access(0, 1, 0, 32'h44, 32'hCAFEF00D, 1, 0,
           32'h0,
           mk(0, 30'h11, 1, 4'hF, 32'hCAFEF00D,
              32'h0, 0, 3, 2));
    access(1, 0, 1, 32'h1, 32'h000000EE, 0, 0,
           32'hAABBCCDD,
           mk(0, 30'h0, 0, 4'h2, 32'hEEEEEEEE,
              32'hCC, 0, 2, 1));

    // Reset in the second BUSY cycle of a stuck load
    exp_q.push_back(mk(2, 30'hC, 0, 4'hF, 32'h0,
                       32'h0, 0, 0, 0));
    slv_never = 1'b1;
    MemReadM  = 1'b1;
    ALUOutM   = 32'h30;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk_rst_outs("midrst");
    MemReadM  = 1'b0;
    ALUOutM   = 32'h0;
    slv_never = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_req", {31'b0, bus_req}, 32'd0);
      chk("post_rst_stall", {31'b0, MemStallM}, 32'd0);
    end

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
